// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host controller.
//   flags_t     : transaction status reported alongside rx_data
//   state_t     : controller states
//   FRAME_LEN   : bits per PS/2 frame (start, 8 data, parity, stop)
//   check_frame : classifies a received device frame
package ps2_pkg;

    localparam int unsigned FRAME_LEN = 11;
    localparam int unsigned BCNT_W    = 4;

    typedef struct packed {
        logic frame_error;
        logic parity_error;
        logic clk_timeout;
        logic rqst_timeout;
    } flags_t;

    typedef enum logic [2:0] {
        INHIBIT,
        IDLE,
        RX,
        TX_RTS,
        TX_BITS,
        TX_ACK
    } state_t;

    localparam flags_t FLAG_NONE   = flags_t'(4'b0000);
    localparam flags_t FLAG_FRAME  = flags_t'(4'b1000);
    localparam flags_t FLAG_PARITY = flags_t'(4'b0100);
    localparam flags_t FLAG_CLK_TO = flags_t'(4'b0010);
    localparam flags_t FLAG_RQST   = flags_t'(4'b0001);

    // Frame layout: [0] start, [8:1] data LSB-first, [9] odd parity, [10] stop.
    // Framing faults take priority over parity so the flags stay one-hot.
    function automatic flags_t check_frame(input logic [FRAME_LEN-1:0] frame);
        flags_t result;
        result = FLAG_NONE;
        if (frame[0] != 1'b0 || frame[FRAME_LEN-1] != 1'b1) begin
            result = FLAG_FRAME;
        end else if ((^frame[FRAME_LEN-2:1]) != 1'b1) begin
            result = FLAG_PARITY;
        end
        return result;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the PS/2 pins into the clk domain.
//   clk, rst_n : system clock, synchronous active-low reset
//   ps2_clk    : raw PS/2 clock pin level
//   ps2_dat    : raw PS/2 data pin level
//   clk_fall   : one-cycle pulse per synchronized ps2_clk falling edge
//   dat_sync   : ps2_dat delayed to line up with clk_fall
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_fall,
    output logic dat_sync
);

    logic [2:0] clk_q;
    logic [2:0] dat_q;

    // Two synchronizer stages plus one history stage for edge detection.
    // Data runs through the same depth so dat_sync shows the level at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_q    <= 3'b111;
            dat_q    <= 3'b111;
            clk_fall <= 1'b0;
        end else begin
            clk_q    <= {clk_q[1:0], ps2_clk};
            dat_q    <= {dat_q[1:0], ps2_dat};
            clk_fall <= clk_q[2] & ~clk_q[1];
        end
    end

    assign dat_sync = dat_q[2];

endmodule

// File: rtl/ps2_controller.sv
// Host-side PS/2 controller: receives device frames, sends host bytes via
// request-to-send, and inhibits the bus while disabled.
//   clk, rst_n : system clock, synchronous active-low reset
//   en         : 1 releases the bus, 0 holds ps2_clk low (inhibit)
//   tx_rqst    : one-cycle request to send tx_data (accepted only when idle)
//   tx_data    : byte to send
//   valid      : one-cycle pulse when a transaction finishes
//   rx_data    : last received byte, held until the next valid
//   flags      : transaction status, held with rx_data
//   ps2_clk    : open-drain PS/2 clock
//   ps2_dat    : open-drain PS/2 data
module ps2_controller
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US      = 100,
    parameter int unsigned RQST_TIMEOUT_US = 15000,
    parameter int unsigned CLK_TIMEOUT_US  = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       tx_rqst,
    input  logic [7:0] tx_data,
    output logic       valid,
    output logic [7:0] rx_data,
    output flags_t     flags,
    inout  wire        ps2_clk,
    inout  wire        ps2_dat
);

    localparam int unsigned CYC_PER_US  = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
    localparam int unsigned RQST_CYC    = CYC_PER_US * RQST_TIMEOUT_US;
    localparam int unsigned CLK_CYC     = CYC_PER_US * CLK_TIMEOUT_US;
    localparam int unsigned TMO_W       = $clog2(RQST_CYC + 1);

    state_t                 state;
    logic                   clk_oe;
    logic                   dat_oe;
    logic [BCNT_W-1:0]      bit_cnt;
    logic [FRAME_LEN-2:0]   rx_sr;
    logic [FRAME_LEN-2:0]   tx_sr;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   fall;
    logic                   dat_s;
    logic [FRAME_LEN-1:0]   rx_frame;

    ps2_line_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .clk_fall (fall),
        .dat_sync (dat_s)
    );

    // Bits arrive at the top and move down; on the last edge the full frame
    // is the incoming bit on top of the ten already collected.
    assign rx_frame = {dat_s, rx_sr};

    // Open drain: only ever pull low or release.
    assign ps2_clk = clk_oe ? 1'b0 : 1'bz;
    assign ps2_dat = dat_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= INHIBIT;
            clk_oe  <= 1'b1;
            dat_oe  <= 1'b0;
            valid   <= 1'b0;
            rx_data <= '0;
            flags   <= FLAG_NONE;
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
            tmo_cnt <= '0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                // Silent abort of whatever was in flight.
                state  <= INHIBIT;
                clk_oe <= 1'b1;
                dat_oe <= 1'b0;
            end else begin
                case (state)
                    INHIBIT: begin
                        clk_oe <= 1'b0;
                        dat_oe <= 1'b0;
                        state  <= IDLE;
                    end
                    IDLE: begin
                        clk_oe  <= 1'b0;
                        dat_oe  <= 1'b0;
                        tmo_cnt <= '0;
                        // A device edge outranks a simultaneous host request.
                        if (fall) begin
                            rx_sr   <= rx_frame[FRAME_LEN-1:1];
                            bit_cnt <= BCNT_W'(1);
                            state   <= RX;
                        end else if (tx_rqst) begin
                            tx_sr  <= {1'b1, ~^tx_data, tx_data};
                            clk_oe <= 1'b1;
                            state  <= TX_RTS;
                        end
                    end
                    RX: begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (fall) begin
                            rx_sr   <= rx_frame[FRAME_LEN-1:1];
                            bit_cnt <= bit_cnt + BCNT_W'(1);
                            if (bit_cnt == BCNT_W'(FRAME_LEN - 1)) begin
                                rx_data <= rx_frame[8:1];
                                flags   <= check_frame(rx_frame);
                                valid   <= 1'b1;
                                state   <= IDLE;
                            end
                        end else if (tmo_cnt == TMO_W'(CLK_CYC - 1)) begin
                            flags <= FLAG_CLK_TO;
                            valid <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    TX_RTS: begin
                        // Hold clk low, then present the start bit and hand the clock over.
                        if (tmo_cnt == TMO_W'(INHIBIT_CYC - 1)) begin
                            clk_oe  <= 1'b0;
                            dat_oe  <= 1'b1;
                            tmo_cnt <= '0;
                            bit_cnt <= '0;
                            state   <= TX_BITS;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    TX_BITS: begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (fall) begin
                            dat_oe  <= ~tx_sr[0];
                            tx_sr   <= tx_sr >> 1;
                            bit_cnt <= bit_cnt + BCNT_W'(1);
                            // First device edge switches from request to frame timeout.
                            if (bit_cnt == '0) begin
                                tmo_cnt <= '0;
                            end
                            if (bit_cnt == BCNT_W'(FRAME_LEN - 2)) begin
                                state <= TX_ACK;
                            end
                        end else if ((bit_cnt == '0 && tmo_cnt == TMO_W'(RQST_CYC - 1)) ||
                                     (bit_cnt != '0 && tmo_cnt == TMO_W'(CLK_CYC - 1))) begin
                            dat_oe <= 1'b0;
                            flags  <= (bit_cnt == '0) ? FLAG_RQST : FLAG_CLK_TO;
                            valid  <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    TX_ACK: begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (fall) begin
                            dat_oe <= 1'b0;
                            flags  <= dat_s ? FLAG_FRAME : FLAG_NONE;
                            valid  <= 1'b1;
                            state  <= IDLE;
                        end else if (tmo_cnt == TMO_W'(CLK_CYC - 1)) begin
                            dat_oe <= 1'b0;
                            flags  <= FLAG_CLK_TO;
                            valid  <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: begin
                        clk_oe <= 1'b1;
                        dat_oe <= 1'b0;
                        state  <= INHIBIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_controller.sv
// Self-checking bench for ps2_controller with a behavioural PS/2 device.
// The system clock is scaled to 1 MHz so one cycle is one microsecond.
module tb_ps2_controller;
    import ps2_pkg::*;

    localparam int unsigned CLK_FREQ_HZ     = 1_000_000;
    localparam int unsigned INHIBIT_US      = 100;
    localparam int unsigned RQST_TIMEOUT_US = 15000;
    localparam int unsigned CLK_TIMEOUT_US  = 2000;
    localparam int INHIBIT_CYC = 100;
    localparam int RQST_CYC    = 15000;
    localparam int CLK_CYC     = 2000;
    localparam int HALF        = 25;   // 20 kHz device clock

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] flg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       tx_rqst;
    logic [7:0] tx_data;
    logic       valid;
    logic [7:0] rx_data;
    flags_t     flags;
    wire        ps2_clk;
    wire        ps2_dat;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_controller #(
        .CLK_FREQ_HZ     (CLK_FREQ_HZ),
        .INHIBIT_US      (INHIBIT_US),
        .RQST_TIMEOUT_US (RQST_TIMEOUT_US),
        .CLK_TIMEOUT_US  (CLK_TIMEOUT_US)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .tx_rqst (tx_rqst),
        .tx_data (tx_data),
        .valid   (valid),
        .rx_data (rx_data),
        .flags   (flags),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   last_valid_cyc = 0;
    int   fall_cyc = 0;
    exp_t exp_q[$];
    logic [7:0] model_rx = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Model: a received frame always loads its byte; error kind follows the injected fault.
    task automatic expect_rx(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        exp_t e;
        e.data = d;
        e.flg  = bad_stop ? 4'b1000 : (bad_par ? 4'b0100 : 4'b0000);
        exp_q.push_back(e);
        model_rx = d;
    endtask

    // Model: timeouts and host transmissions leave rx_data untouched.
    task automatic expect_other(input logic [3:0] f);
        exp_t e;
        e.data = model_rx;
        e.flg  = f;
        exp_q.push_back(e);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // Compare process: every valid must match the next model entry; between
    // valids the outputs must hold the last reported values.
    initial begin
        exp_t e;
        logic       prev_valid = 1'b0;
        logic [7:0] held_data  = 8'h00;
        logic [3:0] held_flags = 4'h0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (valid === 1'b1) begin
                    n_valid++;
                    last_valid_cyc = cyc;
                    check("valid_not_back_to_back", 32'(prev_valid), 32'(0));
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 32'(valid), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        held_data  = e.data;
                        held_flags = e.flg;
                        check("txn_rx_data", 32'(rx_data), 32'(e.data));
                        check("txn_flags", 32'(flags), 32'(e.flg));
                    end
                end else begin
                    check("hold_rx_data", 32'(rx_data), 32'(held_data));
                    check("hold_flags", 32'(flags), 32'(held_flags));
                end
                prev_valid = valid;
            end
        end
    end

    // Device-to-host frame; data changes 5..24 us before each falling edge.
    task automatic dev_send(input logic [10:0] frame, input int nbits);
        int d;
        for (int i = 0; i < nbits; i++) begin
            d = int'($urandom_range(5, 24));
            repeat (HALF - d) @(negedge clk);
            dev_dat_low = ~frame[i];
            repeat (d) @(negedge clk);
            dev_clk_low = 1'b1;
            if (i == 0) fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    // Device side of a host-to-device transfer: reads 10 bits on rising edges, then acks.
    task automatic dev_host_rx(output logic [9:0] bits, output int low_len, output logic start_lvl);
        int w = 0;
        bits = '0;
        while (ps2_clk !== 1'b0 && w < 20) begin @(negedge clk); w++; end
        low_len = 0;
        while (ps2_clk === 1'b0 && low_len < 20000) begin @(negedge clk); low_len++; end
        start_lvl = ps2_dat;
        repeat (30) @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k < 10) bits[k] = ps2_dat;
            dev_clk_low = 1'b0;
            if (k == 9) begin
                repeat (5) @(negedge clk);
                dev_dat_low = 1'b1;
                repeat (HALF - 5) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_valid(input int target, input int budget, input string name);
        int w = 0;
        while (n_valid < target && w < budget) begin @(negedge clk); #1; w++; end
        check(name, 32'(n_valid >= target), 32'(1));
    endtask

    task automatic pulse_rqst(input logic [7:0] d);
        @(negedge clk);
        tx_rqst = 1'b1;
        tx_data = d;
        @(negedge clk);
        tx_rqst = 1'b0;
        tx_data = 8'($urandom);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [9:0] bits;
        logic       start_lvl;
        int         low_len;
        int         t0;
        int         nv;
        bit         bp;
        bit         bs;

        rst_n = 1'b0; en = 1'b0; tx_rqst = 1'b0; tx_data = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_clk_inhibited", 32'(ps2_clk), 32'(0));
        check("reset_dat_released", 32'(ps2_dat), 32'(1));
        check("reset_valid", 32'(valid), 32'(0));
        check("reset_flags", 32'(flags), 32'(0));
        check("reset_rx_data", 32'(rx_data), 32'(0));
        en = 1'b1;
        repeat (5) @(negedge clk);
        check("enable_clk_released", 32'(ps2_clk), 32'(1));
        check("enable_dat_released", 32'(ps2_dat), 32'(1));

        // Good frame 0xA5.
        expect_rx(8'hA5, 1'b0, 1'b0);
        dev_send(make_frame(8'hA5, 1'b0, 1'b0), 11);
        wait_valid(1, 100, "a5_valid_seen");
        repeat (20) @(negedge clk);
        check("a5_rx_data_literal", 32'(rx_data), 32'h0A5);
        check("a5_flags_literal", 32'(flags), 32'(0));
        check("a5_single_pulse", 32'(n_valid), 32'(1));

        // Parity fault, stop fault, and both at once (framing wins).
        expect_rx(8'h3C, 1'b1, 1'b0);
        dev_send(make_frame(8'h3C, 1'b1, 1'b0), 11);
        wait_valid(2, 100, "parity_valid_seen");
        check("parity_flags_literal", 32'(flags), 32'b0100);
        check("parity_rx_data_literal", 32'(rx_data), 32'h03C);
        expect_rx(8'h3C, 1'b0, 1'b1);
        dev_send(make_frame(8'h3C, 1'b0, 1'b1), 11);
        wait_valid(3, 100, "stop_valid_seen");
        check("stop_flags_literal", 32'(flags), 32'b1000);
        expect_rx(8'h81, 1'b1, 1'b1);
        dev_send(make_frame(8'h81, 1'b1, 1'b1), 11);
        wait_valid(4, 100, "both_valid_seen");
        check("both_flags_literal", 32'(flags), 32'b1000);

        // Device stalls after five bits.
        expect_other(4'b0010);
        dev_send(make_frame(8'h5A, 1'b0, 1'b0), 5);
        wait_valid(5, CLK_CYC + 200, "clk_timeout_valid_seen");
        check_range("clk_timeout_latency", last_valid_cyc - fall_cyc, CLK_CYC, CLK_CYC + 8);
        check("clk_timeout_flags_literal", 32'(flags), 32'b0010);
        d = 8'($urandom);
        expect_rx(d, 1'b0, 1'b0);
        dev_send(make_frame(d, 1'b0, 1'b0), 11);
        wait_valid(6, 100, "after_timeout_valid_seen");

        // Host transmit of 0xED with acknowledge.
        expect_other(4'b0000);
        pulse_rqst(8'hED);
        dev_host_rx(bits, low_len, start_lvl);
        check_range("rts_clk_low_len", low_len, INHIBIT_CYC, INHIBIT_CYC + 3);
        check("rts_start_bit", 32'(start_lvl), 32'(0));
        check("tx_data_bits_literal", 32'(bits[7:0]), 32'h0ED);
        check("tx_parity_literal", 32'(bits[8]), 32'(1));
        check("tx_stop_literal", 32'(bits[9]), 32'(1));
        wait_valid(7, 100, "tx_ack_valid_seen");
        check("tx_ack_flags_literal", 32'(flags), 32'(0));

        // Host transmit with a silent device.
        expect_other(4'b0001);
        pulse_rqst(8'($urandom));
        t0 = 0;
        while (ps2_clk !== 1'b0 && t0 < 20) begin @(negedge clk); t0++; end
        t0 = 0;
        while (ps2_clk === 1'b0 && t0 < 1000) begin @(negedge clk); t0++; end
        t0 = cyc;
        wait_valid(8, RQST_CYC + 200, "rqst_timeout_valid_seen");
        check_range("rqst_timeout_latency", last_valid_cyc - t0, RQST_CYC - 1, RQST_CYC + 4);
        check("rqst_timeout_flags_literal", 32'(flags), 32'b0001);
        repeat (3) @(negedge clk);
        check("rqst_timeout_clk_released", 32'(ps2_clk), 32'(1));
        check("rqst_timeout_dat_released", 32'(ps2_dat), 32'(1));

        // Request arriving mid-reception is ignored.
        d = 8'($urandom);
        expect_rx(d, 1'b0, 1'b0);
        fork
            dev_send(make_frame(d, 1'b0, 1'b0), 11);
            begin repeat (150) @(negedge clk); pulse_rqst(8'h55); end
        join
        wait_valid(9, 100, "busy_rqst_valid_seen");
        repeat (20) @(negedge clk);
        check("busy_rqst_clk_released", 32'(ps2_clk), 32'(1));

        // Enable dropped mid-frame: silent abort.
        nv = n_valid;
        dev_send(make_frame(8'hC3, 1'b0, 1'b0), 5);
        en = 1'b0;
        @(negedge clk);
        check("en_drop_clk_low", 32'(ps2_clk), 32'(0));
        repeat (100) @(negedge clk);
        check("en_drop_no_valid", 32'(n_valid), 32'(nv));
        en = 1'b1;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 4) == 0);
            expect_rx(d, bp, bs);
            dev_send(make_frame(d, bp, bs), 11);
            wait_valid(nv + 1 + i, 100, "random_frame_valid_seen");
            repeat ($urandom_range(10, 60)) @(negedge clk);
        end

        repeat (50) @(negedge clk);
        check("all_expected_seen", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
